// File: rtl/pipe_stage_buffer.sv
// Parametrised inter-stage register with valid, stall, flush and
// saturating stall/bubble event counters; updates on the falling clock edge.
module pipe_stage_buffer #(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 32,
   parameter int N_DATA = 3,
   parameter int RD_W   = 6,
   parameter int CNT_W  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [N_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]          in_rd,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     clr_cnt,
   output logic                     out_valid,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [N_DATA*DATA_W-1:0] out_data,
   output logic [RD_W-1:0]          out_rd,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic stall_inc;
   logic bubble_inc;

   // flush beats stall; an invalid capture is also a bubble
   always_comb begin
      stall_inc  = stall & ~flush;
      bubble_inc = flush | (~stall & ~in_valid);
   end

   // ctrl is zeroed on every bubble so write enables never fire downstream
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
         out_rd    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_ctrl  <= in_valid ? in_ctrl : '0;
         out_data  <= in_data;
         out_rd    <= in_rd;
      end
   end

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_inc && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (bubble_inc && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: directed stimulus pushes
// expected output bundles, a monitor pops and compares them.
module tb_pipe_stage_buffer;

   localparam int CTRL_W = 3;
   localparam int DATA_W = 32;
   localparam int N_DATA = 3;
   localparam int RD_W   = 6;
   localparam int CNT_W  = 4;
   localparam int DW     = N_DATA * DATA_W;
   localparam int W      = 1 + CTRL_W + DW + RD_W + 2 * CNT_W;

   logic              clock = 1'b1;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DW-1:0]     in_data = '0;
   logic [RD_W-1:0]   in_rd = '0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic              clr_cnt = 1'b0;
   logic              out_valid;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DW-1:0]     out_data;
   logic [RD_W-1:0]   out_rd;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   pipe_stage_buffer #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .N_DATA(N_DATA),
      .RD_W(RD_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_rd(in_rd),
      .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_ctrl(out_ctrl),
      .out_data(out_data), .out_rd(out_rd),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      string        name;
      logic [W-1:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   event chk_now;

   localparam logic [DW-1:0] D1 = {32'h10, 32'hAA, 32'h4};
   localparam logic [DW-1:0] D2 = {32'h20, 32'hBB, 32'h8};
   localparam logic [DW-1:0] D3 = {32'hDEAD, 32'hBEEF, 32'hC};
   localparam logic [DW-1:0] D4 = {32'h1234, 32'h5678, 32'h9ABC};
   localparam logic [DW-1:0] D5 = {32'hFFFF_0000, 32'h0, 32'h1};
   localparam logic [DW-1:0] D6 = {32'h7, 32'h6, 32'h5};

   task automatic push(input string n, input logic v,
                       input logic [CTRL_W-1:0] c,
                       input logic [DW-1:0] d,
                       input logic [RD_W-1:0] r,
                       input logic [CNT_W-1:0] s,
                       input logic [CNT_W-1:0] b);
      exp_t e;
      e.name = n;
      e.v    = {v, c, d, r, s, b};
      q.push_back(e);
   endtask

   // expectation after the next falling edge, checked on the rising edge
   task automatic edge_check(input string n, input logic v,
                             input logic [CTRL_W-1:0] c,
                             input logic [DW-1:0] d,
                             input logic [RD_W-1:0] r,
                             input logic [CNT_W-1:0] s,
                             input logic [CNT_W-1:0] b);
      push(n, v, c, d, r, s, b);
      @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   task automatic now_check(input string n);
      push(n, 1'b0, '0, '0, '0, '0, '0);
      -> chk_now;
      #1;
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DW-1:0] d, input logic [RD_W-1:0] r);
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
      in_rd    = r;
   endtask

   initial begin
      exp_t         e;
      logic [W-1:0] got;
      forever begin
         @(posedge clock or chk_now);
         if (q.size() > 0) begin
            e   = q.pop_front();
            got = {out_valid, out_ctrl, out_data, out_rd,
                   stall_cnt, bubble_cnt};
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s: got=%h exp=%h", e.name, got, e.v);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: timeout with %0d pending", q.size());
      $fatal(1, "timeout");
   end

   initial begin
      #2 reset = 1'b1;
      now_check("reset_async");
      @(posedge clock);
      #1 reset = 1'b0;

      drive(1'b1, 3'b101, D1, 6'd9);
      edge_check("capture", 1, 3'b101, D1, 6'd9, 0, 0);

      stall = 1'b1;
      drive(1'b1, 3'b010, D2, 6'd3);
      edge_check("stall1", 1, 3'b101, D1, 6'd9, 1, 0);
      edge_check("stall2", 1, 3'b101, D1, 6'd9, 2, 0);
      edge_check("stall3", 1, 3'b101, D1, 6'd9, 3, 0);

      stall = 1'b0;
      edge_check("release", 1, 3'b010, D2, 6'd3, 3, 0);

      flush = 1'b1;
      stall = 1'b1;
      drive(1'b1, 3'b111, D3, 6'd7);
      edge_check("flush_stall", 0, 3'b000, D2, 6'd3, 3, 1);

      flush = 1'b0;
      stall = 1'b0;
      drive(1'b0, 3'b111, D3, 6'd7);
      edge_check("invalid_cap", 0, 3'b000, D3, 6'd7, 3, 2);

      clr_cnt = 1'b1;
      drive(1'b1, 3'b011, D4, 6'd12);
      edge_check("clr_cap", 1, 3'b011, D4, 6'd12, 0, 0);

      clr_cnt = 1'b0;
      stall = 1'b1;
      drive(1'b1, 3'b100, D5, 6'd1);
      repeat (14) @(negedge clock);
      @(posedge clock);
      #1;
      edge_check("sat15", 1, 3'b011, D4, 6'd12, 15, 0);
      repeat (4) @(negedge clock);
      @(posedge clock);
      #1;
      edge_check("sat20", 1, 3'b011, D4, 6'd12, 15, 0);

      clr_cnt = 1'b1;
      edge_check("clr_stall", 1, 3'b011, D4, 6'd12, 0, 0);

      clr_cnt = 1'b0;
      drive(1'b0, 3'b100, D5, 6'd1);
      edge_check("stall_inv", 1, 3'b011, D4, 6'd12, 1, 0);

      stall = 1'b0;
      flush = 1'b1;
      drive(1'b1, 3'b100, D5, 6'd1);
      edge_check("flush_only", 0, 3'b000, D4, 6'd12, 1, 1);

      flush = 1'b0;
      drive(1'b1, 3'b110, D5, 6'd20);
      edge_check("cap2", 1, 3'b110, D5, 6'd20, 1, 1);

      stall = 1'b1;
      drive(1'b1, 3'b001, D6, 6'd33);
      edge_check("pre_reset", 1, 3'b110, D5, 6'd20, 2, 1);

      reset = 1'b1;
      #1;
      now_check("reset_mid");
      reset = 1'b0;
      stall = 1'b0;
      edge_check("resume", 1, 3'b001, D6, 6'd33, 0, 0);

      repeat (5) begin
         if (q.size() > 0) @(posedge clock);
      end
      if (q.size() > 0) begin
         $display("FAIL drain: pending=%0d required=0", q.size());
         bad += q.size();
         total += q.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
